// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin registered mux and its grant logic.
// Mode encodings and parameter bounds only; no logic lives here.
package rr_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int MAX_N     = 16;
  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/rr_mux_reg_if.sv
// N-channel valid/ready funnel bus: producer side (in_*, prio_mode) and consumer side (out_*).
// The slave modport is the mux; the master modport is whatever drives and drains it.
interface rr_mux_reg_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);

  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               prio_mode;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, prio_mode, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, prio_mode, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/rr_grant.sv
// Combinational rotate-scan arbiter: first requester at or after ptr (round-robin) or from 0 (fixed).
// Zero latency; produces no grant when nothing requests.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx,
  output logic            any
);

  int base;
  int c;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    base = (mode == MODE_FIXED) ? 0 : int'(ptr);
    // Explicit modulo wrap keeps the scan correct for non-power-of-two N.
    for (int k = 0; k < N; k++) begin
      c = base + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N:1 funnel with round-robin/fixed arbitration; 1-cycle latency, full throughput.
// Backpressure: out_ready low with a held beat freezes out_* and drops every in_ready.
module rr_mux_reg
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic       clk,
  input  logic       reset,
  rr_mux_reg_if.slave bus
);

  localparam int SELW = $clog2(N);

  logic [WIDTH-1:0] words [N];
  logic [N-1:0]     gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             load;

  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [SELW-1:0]  out_sel_d, out_sel_q;
  logic             out_valid_d, out_valid_q;
  logic [SELW-1:0]  ptr_d, ptr_q;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  rr_grant #(.N(N), .SELW(SELW)) u_grant (
    .req  (bus.in_valid),
    .ptr  (ptr_q),
    .mode (bus.prio_mode),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  assign load = !out_valid_q || bus.out_ready;

  // Reset gating keeps producers from seeing a transfer that the flops will discard.
  assign bus.in_ready = (load && !reset) ? gnt : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = words[gnt_idx];
        out_sel_d  = gnt_idx;
        if (bus.prio_mode == MODE_RR) begin
          ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg (N=4, WIDTH=32) with hand-computed expectations.
module tb_rr_mux_reg;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rr_mux_reg_if #(.N(4), .WIDTH(32)) bus ();

  rr_mux_reg #(.WIDTH(32), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] sel);
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sel"}, 64'(bus.out_sel), 64'(sel));
    chk({tag, "_dat"}, 64'(bus.out_data), 64'(32'hA000_0000 + 32'(sel)));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bus.in_valid  = 4'b1111;
    bus.prio_mode = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held for three edges with every channel requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vld", 64'(bus.out_valid), 64'd0);
      chk("rst_dat", 64'(bus.out_data), 64'd0);
      chk("rst_sel", 64'(bus.out_sel), 64'd0);
      chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    end
    reset = 1'b0;
    #1;
    chk("rr_rdy0", 64'(bus.in_ready), 64'b0001);

    // Round-robin stream: 0,1,2,3,0,1 back to back.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_beat("rr", 2'(i % 4));
    end

    // Backpressure with beat 1 held; ptr is 2.
    bus.out_ready = 1'b0;
    #1;
    chk("bp_rdy_now", 64'(bus.in_ready), 64'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat("bp", 2'd1);
      chk("bp_rdy", 64'(bus.in_ready), 64'b0000);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_beat("bp_rel", 2'd2);

    // Fixed priority with channels 1 and 3: channel 1 always wins; ptr stays 3.
    bus.prio_mode = 1'b1;
    bus.in_valid  = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fx_rdy", 64'(bus.in_ready), 64'b0010);
      tick();
      chk_beat("fx", 2'd1);
    end

    // Back to round-robin with ptr=3 and only channel 3 valid, then wrap to 0.
    bus.prio_mode = 1'b0;
    bus.in_valid  = 4'b1000;
    #1;
    chk("wrap_rdy3", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_beat("wrap3", 2'd3);
    bus.in_valid = 4'b1111;
    #1;
    chk("wrap_rdy0", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_beat("wrap0", 2'd0);

    // Sparse: one-cycle request on channel 2, then idle.
    bus.in_valid = 4'b0100;
    #1;
    chk("sp_rdy", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_beat("sp", 2'd2);
    bus.in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_vld", 64'(bus.out_valid), 64'd0);
      chk("idle_dat", 64'(bus.out_data), 64'hA000_0002);
      chk("idle_sel", 64'(bus.out_sel), 64'd2);
    end

    // Async reset between edges while streaming; ptr is 3 here.
    bus.in_valid = 4'b1111;
    tick();
    chk_beat("ar_pre", 2'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vld", 64'(bus.out_valid), 64'd0);
    chk("ar_dat", 64'(bus.out_data), 64'd0);
    chk("ar_rdy", 64'(bus.in_ready), 64'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_rel_rdy", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_beat("ar_post", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
